dac_scheduler: RTL

Sequences the SPI DAC controller `Dac_ctrl` and shares it between several requesters. Each requester presents a 16-bit DAC word with a level request; the scheduler arbitrates, latches the winning word onto `Dac_ctrl.dato` and drives its active-low `ctrl` strobe for exactly one conversion frame. It then enforces an inter-frame gap before the next grant. The block sits between the acquisition/control logic and the `Dac_ctrl` instance, in the `clk_in` domain.

---
 rtl/dac_sched_pkg.sv | 22 ++
 rtl/dac_rr_arbiter.sv | 55 +++++
 rtl/dac_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dac_sched_pkg.sv
// Shared types and helpers for the DAC scheduler: FSM state encoding, default
// word width and a clog2 helper that never returns less than 1.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int DATA_W_DFLT = 16;

  // Minimum of 1 keeps one-entry counters and indices legal vectors.
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Winner selection for the DAC scheduler. Fixed priority (lowest index) by default;
// define DAC_SCHED_ROUNDROBIN_EN for round-robin with a grant-advanced pointer.
module dac_rr_arbiter
  import dac_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = idx_w(N_REQ)
) (
`ifdef DAC_SCHED_ROUNDROBIN_EN
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             grant_i,
`endif
  input  logic [N_REQ-1:0] req_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  winner_o
);

`ifdef DAC_SCHED_ROUNDROBIN_EN
  logic [ID_W-1:0] ptr_q;

  // Pointer starts at the last index so the first search begins at 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= ID_W'(N_REQ - 1);
    end else if (grant_i) begin
      ptr_q <= winner_o;
    end
  end

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      if (req_i[(int'(ptr_q) + off) % N_REQ]) begin
        winner_o = ID_W'((int'(ptr_q) + off) % N_REQ);
        valid_o  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        winner_o = ID_W'(k);
        valid_o  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/dac_scheduler.sv
// Shares one Dac_ctrl between N_REQ requesters: one frame per grant, then a gap.
// Round-robin arbitration when DAC_SCHED_ROUNDROBIN_EN is defined, else fixed priority.
//   state | meaning
//   IDLE  | waiting; arbitrates once busy has dropped
//   LOAD  | capture winner word, pulse ack
//   SHIFT | frame in progress (dac_ctrl low, one clock later)
//   GAP   | inter-frame gap, frame_done on the last cycle
module dac_scheduler
  import dac_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int FRAME_CYCLES = 70,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_dato,
  output logic [N_REQ-1:0]          ack,
  output logic                      dac_ctrl,
  output logic [DATA_W-1:0]         dac_dato,
  output logic                      busy,
  output logic [idx_w(N_REQ)-1:0]   grant_id,
  output logic                      frame_done
);

  localparam int ID_W  = idx_w(N_REQ);
  localparam int CNT_W = idx_w((FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES);
  localparam logic [CNT_W-1:0] FRAME_TC = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]  dac_dato_q, dac_dato_d;
  logic               dac_ctrl_q, dac_ctrl_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               arb_valid;
  logic [ID_W-1:0]    arb_winner;
  logic               arb_grant;

  dac_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
`ifdef DAC_SCHED_ROUNDROBIN_EN
    .clk_i    (clk_in),
    .rst_i    (rst),
    .grant_i  (arb_grant),
`endif
    .req_i    (req),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_id_d   = grant_id_q;
    ack_d        = '0;
    dac_dato_d   = dac_dato_q;
    frame_done_d = 1'b0;
    arb_grant    = 1'b0;
    dac_ctrl_d   = (state_q != SHIFT);
    busy_d       = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // Waiting for busy to fall guarantees one visible idle clock between frames.
        if (arb_valid && !busy_q) begin
          state_d    = LOAD;
          grant_id_d = arb_winner;
          arb_grant  = 1'b1;
          cnt_d      = '0;
        end
      end
      LOAD: begin
        ack_d[grant_id_q] = 1'b1;
        dac_dato_d        = req_dato[int'(grant_id_q)*DATA_W +: DATA_W];
        state_d           = SHIFT;
        cnt_d             = '0;
      end
      SHIFT: begin
        if (cnt_q == FRAME_TC) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_TC) begin
          state_d      = IDLE;
          cnt_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_id_q   <= '0;
      ack_q        <= '0;
      dac_dato_q   <= '0;
      dac_ctrl_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_id_q   <= grant_id_d;
      ack_q        <= ack_d;
      dac_dato_q   <= dac_dato_d;
      dac_ctrl_q   <= dac_ctrl_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ack        = ack_q;
  assign dac_ctrl   = dac_ctrl_q;
  assign dac_dato   = dac_dato_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;

endmodule
